// File: rtl/fifo_pkg.sv
// Shared definitions for the async fifo and its frame reader: reader state
// encoding, header field position and the ceiling-log2 helper.
package fifo_pkg;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2
  } rd_state_t;

  localparam int unsigned LEN_LSB = 0;

  // Bits needed to count 0..value-1; never returns less than 1.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_frame_reader.sv
// Pulls length-prefixed frames of fifo words and serialises them MSB byte
// first onto a valid/ready byte stream with end-of-frame marking.
module fifo_frame_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clock_out,
  input  logic                  rst_out_n,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_valid,
  output logic                  fifo_ack,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  len_error,
  output logic [15:0]           frame_count
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned BC_W  = clogb2(BYTES);

  localparam logic [BC_W-1:0]      BC_LAST = BC_W'(BYTES - 1);
  localparam logic [BC_W-1:0]      BC_ONE  = BC_W'(1);
  localparam logic [LEN_WIDTH-1:0] WL_ONE  = LEN_WIDTH'(1);

  rd_state_t             state, next_state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [LEN_WIDTH-1:0]  words_left;
  logic [BC_W-1:0]       byte_cnt;
  logic [LEN_WIDTH-1:0]  hdr_len;
  logic                  last_byte;
  logic                  more_words;
  logic                  consume;
  logic                  accept;

  assign hdr_len    = fifo_data[LEN_LSB +: LEN_WIDTH];
  assign last_byte  = (byte_cnt == '0);
  assign more_words = (words_left != '0);

  // Outputs are pure decodes of registers, so they stay stable while stalled.
  assign out_valid = (state == SEND);
  assign out_data  = shreg[DATA_WIDTH-1 -: 8];
  assign out_last  = (state == SEND) && last_byte && !more_words;

  assign consume = fifo_ack & fifo_valid;
  assign accept  = out_valid & out_ready;

  always_ff @(posedge clock_out or negedge rst_out_n) begin
    if (!rst_out_n) state <= HEADER;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_ack   = 1'b0;
    case (state)
      HEADER: begin
        fifo_ack = fifo_valid;
        if (fifo_valid && hdr_len != '0) next_state = FETCH;
      end
      FETCH: begin
        fifo_ack = fifo_valid;
        if (fifo_valid) next_state = SEND;
      end
      SEND: begin
        if (out_ready && last_byte) begin
          if (!more_words)     next_state = HEADER;
          else if (fifo_valid) fifo_ack   = 1'b1;
          else                 next_state = FETCH;
        end
      end
      default: next_state = HEADER;
    endcase
    // No word may be popped while the reader is held in reset.
    if (!rst_out_n) fifo_ack = 1'b0;
  end

  always_ff @(posedge clock_out or negedge rst_out_n) begin
    if (!rst_out_n) begin
      shreg       <= '0;
      words_left  <= '0;
      byte_cnt    <= '0;
      frame_done  <= 1'b0;
      len_error   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      len_error  <= 1'b0;
      case (state)
        HEADER: begin
          if (consume) begin
            if (hdr_len == '0) len_error  <= 1'b1;
            else               words_left <= hdr_len;
          end
        end
        FETCH: begin
          if (consume) begin
            shreg      <= fifo_data;
            byte_cnt   <= BC_LAST;
            words_left <= words_left - WL_ONE;
          end
        end
        SEND: begin
          if (accept) begin
            if (!last_byte) begin
              shreg    <= {shreg[DATA_WIDTH-9:0], 8'h00};
              byte_cnt <= byte_cnt - BC_ONE;
            end else if (!more_words) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else if (consume) begin
              shreg      <= fifo_data;
              byte_cnt   <= BC_LAST;
              words_left <= words_left - WL_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader, fed by a simple behavioural fifo.
module tb_fifo_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ack;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        frame_done;
  logic        len_error;
  logic [15:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_frame_reader #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clock_out  (clk),
    .rst_out_n  (rst_n),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_ack   (fifo_ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_done (frame_done),
    .len_error  (len_error),
    .frame_count(frame_count)
  );

  // Behavioural fifo: writes from the stimulus, reads on fifo_ack & fifo_valid.
  logic [31:0] mem [4096];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic        flush_req;

  always @(posedge clk) begin : fifo_model
    int unsigned rp;
    rp = rd_ptr;
    if (flush_req) rp = wr_ptr;
    else if (fifo_ack && fifo_valid) rp = rp + 1;
    rd_ptr     <= rp;
    fifo_valid <= (rp != wr_ptr);
    fifo_data  <= mem[rp % 4096];
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr % 4096] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Monitor: records bytes about to be accepted and counts pulses.
  logic [7:0] got_data [$];
  logic       got_last [$];
  int         got_cyc  [$];
  int cyc = 0;
  int done_cnt = 0, lerr_cnt = 0, zb_cnt = 0, stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
      end
      if (frame_done) done_cnt++;
      if (len_error)  lerr_cnt++;
      if (fifo_ack && fifo_valid && out_valid) zb_cnt++;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    flush_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    flush_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt >= want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    flush_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_last !== 1'b0)     begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_tests++; if (out_data !== 8'h00)    begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_tests++; if (frame_done !== 1'b0)   begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_tests++; if (len_error !== 1'b0)    begin n_fail++; $display("FAIL reset_len_error got %b want 0", len_error); end
    n_tests++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    n_tests++; if (fifo_ack !== 1'b0)     begin n_fail++; $display("FAIL reset_fifo_ack got %b want 0", fifo_ack); end
    flush_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [7:0] exp_b [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
    int base, d0, zb0;
    bit ok;
    do_reset();
    base = got_data.size(); d0 = done_cnt; zb0 = zb_cnt;
    out_ready = 1'b1;
    push(32'h0000_0002); push(32'hA1B2_C3D4); push(32'h0102_0304);
    wait_done(d0 + 1, 200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout got no frame_done want frame_done"); end
    repeat (3) @(negedge clk);
    n_tests++; if (got_data.size() - base !== 8) begin n_fail++; $display("FAIL single_count got %0d want 8", got_data.size() - base); end
    for (int i = 0; i < 8; i++) begin
      if (base + i < got_data.size()) begin
        n_tests++;
        if (got_data[base+i] !== exp_b[i] || got_last[base+i] !== (i == 7) || got_cyc[base+i] - got_cyc[base] !== i) begin
          n_fail++;
          $display("FAIL single_byte%0d got %h last %b dcyc %0d want %h last %b dcyc %0d", i,
                   got_data[base+i], got_last[base+i], got_cyc[base+i] - got_cyc[base], exp_b[i], (i == 7), i);
        end
      end
    end
    n_tests++; if (done_cnt - d0 !== 1)     begin n_fail++; $display("FAIL single_done got %0d want 1", done_cnt - d0); end
    n_tests++; if (frame_count !== 16'd1)   begin n_fail++; $display("FAIL single_frame_count got %0d want 1", frame_count); end
    n_tests++; if (zb_cnt - zb0 !== 1)      begin n_fail++; $display("FAIL single_zero_bubble got %0d want 1", zb_cnt - zb0); end
    n_tests++; if (out_valid !== 1'b0)      begin n_fail++; $display("FAIL single_idle got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
    int base, d0, s0;
    bit ok;
    do_reset();
    base = got_data.size(); d0 = done_cnt; s0 = stall_err;
    out_ready = 1'b1;
    push(32'h0000_0002); push(32'hA1B2_C3D4); push(32'h0102_0304);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
      if (done_cnt >= d0 + 1) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got no frame_done want frame_done"); end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (got_data.size() - base !== 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", got_data.size() - base); end
    for (int i = 0; i < 8; i++) begin
      if (base + i < got_data.size()) begin
        n_tests++;
        if (got_data[base+i] !== exp_b[i] || got_last[base+i] !== (i == 7)) begin
          n_fail++;
          $display("FAIL bp_byte%0d got %h last %b want %h last %b", i, got_data[base+i], got_last[base+i], exp_b[i], (i == 7));
        end
      end
    end
    n_tests++; if (stall_err - s0 !== 0)  begin n_fail++; $display("FAIL bp_stable got %0d violations want 0", stall_err - s0); end
    n_tests++; if (done_cnt - d0 !== 1)   begin n_fail++; $display("FAIL bp_done got %0d want 1", done_cnt - d0); end
    n_tests++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL bp_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_zero_len();
    logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    int base, d0, l0;
    bit ok;
    do_reset();
    base = got_data.size(); d0 = done_cnt; l0 = lerr_cnt;
    out_ready = 1'b1;
    push(32'h0000_0000); push(32'h0000_0001); push(32'hDEAD_BEEF);
    wait_done(d0 + 1, 200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL zl_timeout got no frame_done want frame_done"); end
    repeat (3) @(negedge clk);
    n_tests++; if (lerr_cnt - l0 !== 1) begin n_fail++; $display("FAIL zl_len_error got %0d want 1", lerr_cnt - l0); end
    n_tests++; if (got_data.size() - base !== 4) begin n_fail++; $display("FAIL zl_count got %0d want 4", got_data.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < got_data.size()) begin
        n_tests++;
        if (got_data[base+i] !== exp_b[i] || got_last[base+i] !== (i == 3)) begin
          n_fail++;
          $display("FAIL zl_byte%0d got %h last %b want %h last %b", i, got_data[base+i], got_last[base+i], exp_b[i], (i == 3));
        end
      end
    end
    n_tests++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL zl_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_underrun();
    logic [31:0] words [3] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    logic [31:0] w;
    int base, d0, mism;
    bit ok;
    do_reset();
    base = got_data.size(); d0 = done_cnt;
    out_ready = 1'b1;
    push(32'h0000_0003);
    for (int k = 0; k < 3; k++) begin
      repeat (20) @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ur_wait%0d got out_valid %b want 0", k, out_valid); end
      push(words[k]);
    end
    wait_done(d0 + 1, 200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ur_timeout got no frame_done want frame_done"); end
    repeat (3) @(negedge clk);
    n_tests++; if (got_data.size() - base !== 12) begin n_fail++; $display("FAIL ur_count got %0d want 12", got_data.size() - base); end
    mism = 0;
    for (int i = 0; i < 12; i++) begin
      w = words[i/4];
      if (base + i >= got_data.size() || got_data[base+i] !== w[31-8*(i%4) -: 8] || got_last[base+i] !== (i == 11))
        mism++;
    end
    n_tests++; if (mism !== 0) begin n_fail++; $display("FAIL ur_bytes got %0d mismatched bytes want 0", mism); end
    n_tests++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL ur_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    do_reset();
    base = got_data.size();
    out_ready = 1'b1;
    push(32'h0000_0002); push(32'hA1B2_C3D4); push(32'h0102_0304);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (got_data.size() - base >= 3) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rm_timeout got %0d bytes want 3", got_data.size() - base); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL rm_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_last !== 1'b0)     begin n_fail++; $display("FAIL rm_out_last got %b want 0", out_last); end
    n_tests++; if (out_data !== 8'h00)    begin n_fail++; $display("FAIL rm_out_data got %h want 00", out_data); end
    n_tests++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rm_frame_count got %0d want 0", frame_count); end
    n_tests++; if (fifo_ack !== 1'b0)     begin n_fail++; $display("FAIL rm_fifo_ack got %b want 0 (fifo_valid %b)", fifo_ack, fifo_valid); end
    flush_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    flush_req = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || frame_count !== 16'd0) begin
      n_fail++; $display("FAIL rm_after got valid %b count %0d want valid 0 count 0", out_valid, frame_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [$];
    logic       exp_l [$];
    logic [31:0] r;
    int L, total_words, base, d0, zb0, s0, l0, mism, first_bad;
    bit ok;
    do_reset();
    base = got_data.size(); d0 = done_cnt; zb0 = zb_cnt; s0 = stall_err; l0 = lerr_cnt;
    total_words = 0;
    for (int f = 0; f < 100; f++) begin
      L = $urandom_range(1, 8);
      r = $urandom();
      push({r[31:16], 16'(L)});
      total_words += L;
      for (int w = 0; w < L; w++) begin
        r = $urandom();
        push(r);
        for (int b = 0; b < 4; b++) begin
          exp_d.push_back(r[31-8*b -: 8]);
          exp_l.push_back(w == L - 1 && b == 3);
        end
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
      if (done_cnt >= d0 + 100) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout got %0d frames want 100", done_cnt - d0); end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (got_data.size() - base !== exp_d.size()) begin
      n_fail++; $display("FAIL b2b_count got %0d want %0d", got_data.size() - base, exp_d.size());
    end
    mism = 0; first_bad = -1;
    for (int i = 0; i < exp_d.size(); i++) begin
      if (base + i >= got_data.size() || got_data[base+i] !== exp_d[i] || got_last[base+i] !== exp_l[i]) begin
        if (first_bad < 0) first_bad = i;
        mism++;
      end
    end
    n_tests++; if (mism !== 0) begin n_fail++; $display("FAIL b2b_bytes got %0d mismatched (first at %0d) want 0", mism, first_bad); end
    n_tests++; if (frame_count !== 16'd100) begin n_fail++; $display("FAIL b2b_frame_count got %0d want 100", frame_count); end
    n_tests++; if (zb_cnt - zb0 !== total_words - 100) begin
      n_fail++; $display("FAIL b2b_zero_bubble got %0d want %0d", zb_cnt - zb0, total_words - 100);
    end
    n_tests++; if (stall_err - s0 !== 0) begin n_fail++; $display("FAIL b2b_stable got %0d violations want 0", stall_err - s0); end
    n_tests++; if (lerr_cnt - l0 !== 0)  begin n_fail++; $display("FAIL b2b_len_error got %0d want 0", lerr_cnt - l0); end
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    flush_req = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_zero_len();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_frame_reader.md
# fifo_frame_reader

Consumer for the read side of the asynchronous fifo. Pulls length-prefixed frames of DATA_WIDTH-bit words out of the fifo's data-out interface and serializes them into a byte stream with valid/ready handshake and end-of-frame marking. Sits entirely in the fifo's output clock domain, between the fifo and the byte-oriented downstream logic.

## Interface
- DATA_WIDTH, 32: fifo word width. Must be a multiple of 8 and at least 16.
- LEN_WIDTH, 16: header length field width. Must be at most DATA_WIDTH.
- BYTES, DATA_WIDTH/8: derived localparam, bytes per word.

Ports:
- clock_out  in  1  block clock; same clock as the fifo read side
- rst_out_n  in  1  asynchronous, active-low reset
- fifo_data  in  DATA_WIDTH  fifo data_out; sampled only when fifo_valid=1
- fifo_valid  in  1  fifo data_out_valid
- fifo_ack  out  1  fifo data_out_ack; a word is consumed in any cycle where fifo_ack & fifo_valid
- out_data  out  8  current byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the byte when out_valid & out_ready
- out_last  out  1  byte is the final byte of the frame
- frame_done  out  1  one-cycle pulse on acceptance of the out_last byte
- len_error  out  1  one-cycle pulse when a zero-length header is consumed
- frame_count  out  16  number of completed frames; wraps at 0xFFFF

## Operation
- Frame format:
  - Header word: length L = fifo_data[LEN_WIDTH-1:0], in words. Upper header bits are ignored.
  - The header is followed by L payload words.
  - Each payload word is emitted MSB byte first (big-endian).
- States:
  - HEADER:
    - fifo_ack = fifo_valid.
    - On consume with L=0: pulse len_error and stay in HEADER. No bytes are emitted.
    - On consume with L≠0: words_left ← L, then go to FETCH.
  - FETCH:
    - fifo_ack = fifo_valid.
    - On consume: shreg ← fifo_data, byte_cnt ← BYTES-1, words_left ← words_left-1, then go to SEND.
  - SEND:
    - out_valid=1, out_data=shreg[DATA_WIDTH-1 -: 8].
    - out_last = (byte_cnt==0 && words_left==0).
    - On accept with byte_cnt≠0: shift shreg left by 8 and decrement byte_cnt.
    - On accept with byte_cnt==0 and words_left==0: go to HEADER, pulse frame_done, increment frame_count.
    - On accept with byte_cnt==0 and words_left≠0:
      - If fifo_valid=1: fifo_ack=1, load the next word directly (zero-bubble), stay in SEND.
      - Otherwise: go to FETCH.
  - fifo_ack is 0 in SEND except in the zero-bubble case.
- Arithmetic and widths:
  - words_left is LEN_WIDTH bits and never underflows.
  - byte_cnt is clog2(BYTES) bits.
  - frame_count is modulo 2^16.
- Reset (including mid-frame):
  - State goes to HEADER.
  - out_valid=0, out_last=0, frame_done=0, len_error=0, frame_count=0, shreg=0, words_left=0, byte_cnt=0.
  - A partially sent frame is abandoned. Remaining payload words left in the fifo will be interpreted as a header after reset; frame resynchronization is the system's responsibility.
- The fifo running empty mid-frame stalls in FETCH indefinitely. There is no timeout.

## Timing
- fifo_ack is combinational from state, fifo_valid and out_ready. There is no other combinational path from inputs to outputs.
- out_valid, out_data and out_last are registered.
- While out_valid & !out_ready, out_data and out_last hold stable.
- Latency:
  - Header consumed at cycle t → FETCH at t+1.
  - First payload word consumed at t+1 (if fifo_valid) → first byte valid at t+2.
- Throughput with out_ready=1 and the fifo non-empty: 1 byte per cycle within a frame.
- Overhead: 2 idle cycles between frames (header + fetch).
- frame_done and len_error assert in the cycle after the triggering event and last exactly one cycle.

## Structure
- Shared package fifo_pkg holds:
  - the state encoding (HEADER=2'd0, FETCH=2'd1, SEND=2'd2)
  - LEN_LSB=0
  - the clogb2 function, shared with the fifo
- No sub-module. Control and the shift register are one file of about 150–250 lines.
- The top-level testbench instantiates the fifo and fifo_frame_reader back-to-back.

## Test plan
- Single frame: write {32'h0000_0002, 32'hA1B2_C3D4, 32'h0102_0304}, out_ready=1.
  - Expect bytes A1 B2 C3 D4 01 02 03 04 on consecutive cycles.
  - out_last only on 04; frame_done pulses once; frame_count=1.
- Backpressure: same frame, out_ready toggling 1/0 every cycle.
  - Identical byte sequence, out_data stable while stalled, no lost or duplicate bytes.
- Zero-length header: write {0x0000_0000, 0x0000_0001, 0xDEAD_BEEF}.
  - len_error pulses once, then bytes DE AD BE EF with out_last on EF; frame_count=1.
- Fifo underrun: header L=3 written, with payload words written 20 cycles apart.
  - Reader waits in FETCH with out_valid=0; all 12 bytes emitted in order.
- Reset mid-frame: assert rst_out_n low after 3 bytes of a 2-word frame.
  - All outputs go to reset values immediately; frame_count=0; fifo_ack=0 during reset.
- Back-to-back frames: 100 random frames with L in 1..8 and random out_ready.
  - Scoreboard match of every byte; frame_count=100.
  - Zero-bubble word transition observed whenever fifo_valid=1.
